// File: rtl/line_pixel_writer_if.sv
// rtl/line_pixel_writer_if.sv - pixel-in / framebuffer-out handshake bundle for line_pixel_writer
interface line_pixel_writer_if #(
   parameter int ADDR_W  = 18,
   parameter int COLOR_W = 8
);
   logic               pix_valid;
   logic               pix_ready;
   logic [31:0]        pix_x;
   logic [31:0]        pix_y;
   logic [COLOR_W-1:0] pix_color;
   logic               pix_last;
   logic               fb_we;
   logic [ADDR_W-1:0]  fb_addr;
   logic [COLOR_W-1:0] fb_data;
   logic               fb_ready;
   logic               line_done;
   logic               busy;

   // pixel source and framebuffer sink side
   modport master (
      output pix_valid, pix_x, pix_y, pix_color, pix_last, fb_ready,
      input  pix_ready, fb_we, fb_addr, fb_data, line_done, busy
   );

   // writer side
   modport slave (
      input  pix_valid, pix_x, pix_y, pix_color, pix_last, fb_ready,
      output pix_ready, fb_we, fb_addr, fb_data, line_done, busy
   );
endinterface

// File: rtl/line_pixel_writer.sv
// rtl/line_pixel_writer.sv - clip, address and buffer rasteriser pixels into the framebuffer; optional PIX_DEDUP_EN
module line_pixel_writer #(
   parameter int H_RES      = 512,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 18,
   parameter int COLOR_W    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   line_pixel_writer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t             state, state_n;
   logic [ADDR_W-1:0]  mem_addr [FIFO_DEPTH];
   logic [COLOR_W-1:0] mem_data [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count, count_n;
   logic               pix_ready_q;
   logic               accept, in_range, is_dup, push, pop, fifo_empty, line_done_c;
   logic [ADDR_W-1:0]  addr_calc;

   assign accept     = bus.pix_valid & pix_ready_q;
   assign in_range   = (bus.pix_x < 32'(H_RES)) && (bus.pix_y < 32'(V_RES));
   // modulo-2**ADDR_W arithmetic is exact for every pixel that survives clipping
   assign addr_calc  = bus.pix_y[ADDR_W-1:0] * ADDR_W'(H_RES) + bus.pix_x[ADDR_W-1:0];
   assign fifo_empty = (count == '0);
   assign push       = accept & in_range & ~is_dup;
   assign pop        = ~fifo_empty & bus.fb_ready;

`ifdef PIX_DEDUP_EN
   logic              hist_valid;
   logic [ADDR_W-1:0] hist_addr;

   // address uniquely identifies an in-range (x,y), so it serves as the repeat key
   assign is_dup = hist_valid && (hist_addr == addr_calc);

   // remember the last pushed pixel of the current line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_valid <= 1'b0;
         hist_addr  <= '0;
      end else if (line_done_c) begin
         hist_valid <= 1'b0;
      end else if (push) begin
         hist_valid <= 1'b1;
         hist_addr  <= addr_calc;
      end
   end
`else
   assign is_dup = 1'b0;
`endif

   // occupancy after this cycle's push/pop
   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_n;
      end
   end

   // FIFO storage; contents are meaningless while empty so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= addr_calc;
         mem_data[wr_ptr] <= bus.pix_color;
      end
   end

   // line sequencing: a last pixel (clipped or not) closes the line and drains the FIFO
   always_comb begin
      state_n     = state;
      line_done_c = 1'b0;
      case (state)
         IDLE:    if (accept) state_n = bus.pix_last ? FLUSH : ACTIVE;
         ACTIVE:  if (accept && bus.pix_last) state_n = FLUSH;
         FLUSH:   if (fifo_empty) begin
                     line_done_c = 1'b1;
                     state_n     = IDLE;
                  end
         default: state_n = IDLE;
      endcase
   end

   // state and registered ready, looking ahead at next occupancy and state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pix_ready_q <= 1'b0;
      end else begin
         state       <= state_n;
         pix_ready_q <= (count_n != CNT_W'(FIFO_DEPTH)) && (state_n != FLUSH);
      end
   end

   assign bus.pix_ready = pix_ready_q;
   assign bus.fb_we     = ~fifo_empty;
   assign bus.fb_addr   = fifo_empty ? '0 : mem_addr[rd_ptr];
   assign bus.fb_data   = fifo_empty ? '0 : mem_data[rd_ptr];
   assign bus.line_done = line_done_c;
   assign bus.busy      = (state != IDLE) || ~fifo_empty;
endmodule

// File: tb/tb_line_pixel_writer.sv
// tb/tb_line_pixel_writer.sv - directed and randomized bench for line_pixel_writer
module tb_line_pixel_writer;
   localparam int H = 512;
   localparam int V = 480;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   int   n_lines_exp = 0;
   bit   rand_ready = 0;

   logic [25:0] exp_q[$];
   logic [25:0] obs_q[$];
   bit          hist_v = 0;
   logic [31:0] hist_a = 0;

   bit          prev_stall = 0;
   logic [17:0] prev_addr;
   logic [7:0]  prev_data;

   line_pixel_writer_if #(.ADDR_W(18), .COLOR_W(8)) bus ();

   line_pixel_writer dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference: clip, linear address, optional repeat suppression within a line
   task automatic model_accept(input logic [31:0] x, input logic [31:0] y,
                               input logic [7:0] c, input logic last);
      logic [31:0] a;
      bit dup;
      if (x < H && y < V) begin
         a = y * H + x;
         dup = 0;
`ifdef PIX_DEDUP_EN
         dup = hist_v && (hist_a == a);
`endif
         if (!dup) begin
            exp_q.push_back({a[17:0], c});
            hist_v = 1;
            hist_a = a;
         end
      end
      if (last) begin
         hist_v = 0;
         n_lines_exp++;
      end
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input logic [7:0] c, input logic last);
      int k;
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_x     = x;
      bus.pix_y     = y;
      bus.pix_color = c;
      bus.pix_last  = last;
      k = 0;
      while (!bus.pix_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("send_ready", {31'b0, bus.pix_ready}, 1);
      @(posedge clk);
      model_accept(x, y, c, last);
      #1;
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 bus.fb_ready = v;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (bus.busy && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", {31'b0, bus.busy}, 0);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk({tag, "_write"}, {6'b0, obs_q[i]}, {6'b0, exp_q[i]});
      obs_q.delete();
      exp_q.delete();
   endtask

   // write/line_done monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("hold_we", {31'b0, bus.fb_we}, 1);
            chk("hold_addr", {14'b0, bus.fb_addr}, {14'b0, prev_addr});
            chk("hold_data", {24'b0, bus.fb_data}, {24'b0, prev_data});
         end
         if (bus.fb_we && bus.fb_ready) obs_q.push_back({bus.fb_addr, bus.fb_data});
         if (bus.line_done) begin
            n_done++;
            chk("done_fifo_empty", {31'b0, bus.fb_we}, 0);
         end
         prev_stall = bus.fb_we && !bus.fb_ready;
         prev_addr  = bus.fb_addr;
         prev_data  = bus.fb_data;
      end
   end

   // random framebuffer back-pressure
   always @(posedge clk) begin
      if (rand_ready) begin
         #2 bus.fb_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int d0;
      int len;
      logic [31:0] rx, ry;
      rst = 1'b1;
      bus.pix_valid = 0; bus.pix_x = 0; bus.pix_y = 0;
      bus.pix_color = 0; bus.pix_last = 0; bus.fb_ready = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_pix_ready", {31'b0, bus.pix_ready}, 0);
      chk("rst_fb_we", {31'b0, bus.fb_we}, 0);
      chk("rst_fb_addr", {14'b0, bus.fb_addr}, 0);
      chk("rst_fb_data", {24'b0, bus.fb_data}, 0);
      chk("rst_line_done", {31'b0, bus.line_done}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", {31'b0, bus.pix_ready}, 1);

      // 1: free-flowing line, one-cycle write latency
      set_ready(1);
      d0 = n_done;
      send(10, 20, 8'h11, 0);
      @(negedge clk);
      chk("t1_we0", {31'b0, bus.fb_we}, 1);
      chk("t1_addr0", {14'b0, bus.fb_addr}, 10250);
      send(11, 21, 8'h22, 0);
      @(negedge clk);
      chk("t1_addr1", {14'b0, bus.fb_addr}, 10763);
      chk("t1_data1", {24'b0, bus.fb_data}, 8'h22);
      send(12, 22, 8'h33, 1);
      @(negedge clk);
      chk("t1_addr2", {14'b0, bus.fb_addr}, 11276);
      chk("t1_done_early", {31'b0, bus.line_done}, 0);
      @(negedge clk);
      chk("t1_done", {31'b0, bus.line_done}, 1);
      chk("t1_we_off", {31'b0, bus.fb_we}, 0);
      @(negedge clk);
      chk("t1_done_once", {31'b0, bus.line_done}, 0);
      wait_idle();
      compare_writes("t1");
      chk("t1_lines", n_done - d0, 1);

      // 2: stalled framebuffer fills the FIFO
      set_ready(0);
      d0 = n_done;
      for (int i = 0; i < 4; i++) send(100 + i, 50, 8'(i + 1), 0);
      @(negedge clk);
      chk("t2_full_ready", {31'b0, bus.pix_ready}, 0);
      repeat (3) begin
         @(negedge clk);
         chk("t2_stall_ready", {31'b0, bus.pix_ready}, 0);
         chk("t2_stall_addr", {14'b0, bus.fb_addr}, 25700);
      end
      set_ready(1);
      send(200, 60, 8'h55, 1);
      wait_idle();
      compare_writes("t2");
      chk("t2_lines", n_done - d0, 1);

      // 3: clipping, including a negative X
      d0 = n_done;
      send(600, 5, 8'h01, 0);
      send(5, 500, 8'h02, 0);
      send(32'hFFFF_FFFF, 3, 8'h03, 0);
      send(7, 7, 8'h04, 1);
      wait_idle();
      chk("t3_nwrites", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("t3_addr", {14'b0, obs_q[0][25:8]}, 3591);
      compare_writes("t3");
      chk("t3_lines", n_done - d0, 1);

      // 4: clipped single-pixel line
      d0 = n_done;
      send(1000, 0, 8'h77, 1);
      @(negedge clk);
      chk("t4_no_we", {31'b0, bus.fb_we}, 0);
      chk("t4_done", {31'b0, bus.line_done}, 1);
      @(negedge clk);
      chk("t4_done_off", {31'b0, bus.line_done}, 0);
      chk("t4_idle", {31'b0, bus.busy}, 0);
      chk("t4_ready", {31'b0, bus.pix_ready}, 1);
      compare_writes("t4");
      chk("t4_lines", n_done - d0, 1);

      // 5: asynchronous reset with queued entries
      set_ready(0);
      for (int i = 0; i < 3; i++) send(30 + i, 40, 8'(8'h40 + i), 0);
      @(negedge clk);
      chk("t5_busy_before", {31'b0, bus.busy}, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_we", {31'b0, bus.fb_we}, 0);
      chk("t5_rst_ready", {31'b0, bus.pix_ready}, 0);
      chk("t5_rst_busy", {31'b0, bus.busy}, 0);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      hist_v = 0;
      d0 = n_done;
      set_ready(1);
      send(3, 2, 8'h66, 0);
      send(3, 3, 8'h67, 1);
      wait_idle();
      compare_writes("t5");
      chk("t5_lines", n_done - d0, 1);

      // 6: repeated coordinate
      d0 = n_done;
      send(4, 4, 8'h09, 0);
      send(4, 4, 8'h09, 0);
      send(5, 4, 8'h0A, 1);
      wait_idle();
`ifdef PIX_DEDUP_EN
      chk("t6_nwrites", obs_q.size(), 2);
`else
      chk("t6_nwrites", obs_q.size(), 3);
`endif
      compare_writes("t6");
      chk("t6_lines", n_done - d0, 1);

      // randomized lines under random back-pressure
      d0 = n_done;
      n_lines_exp = 0;
      rand_ready = 1;
      rx = 0; ry = 0;
      for (int l = 0; l < 20; l++) begin
         len = $urandom_range(1, 6);
         for (int p = 0; p < len; p++) begin
            if (!(p > 0 && $urandom_range(0, 3) == 0)) begin
               if ($urandom_range(0, 7) == 0) rx = 32'hFFFF_FFFF - $urandom_range(0, 5);
               else rx = $urandom_range(0, 600);
               ry = $urandom_range(0, 520);
            end
            send(rx, ry, 8'($urandom), (p == len - 1));
         end
      end
      wait_idle();
      rand_ready = 0;
      repeat (2) @(negedge clk);
      compare_writes("rand");
      chk("rand_lines", n_done - d0, n_lines_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
